// File: rtl/multichan_delay_pipe.sv
// Multi-channel sideband delay line. Each channel has its own runtime-selectable
// tap into a shared shift register. All channels share one valid shift chain.
// The output register stands in for the last stage, so the total latency equals
// the selected delay.
module multichan_delay_pipe #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         ce_in,
    input  logic                         flush_in,
    input  logic                         valid_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH*SEL_W-1:0]      delay_sel_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid_out
);

    // Entry [k] holds delay stage k+1.
    logic [DATA_WIDTH-1:0] stage      [DEPTH][NUM_CH];
    logic [DATA_WIDTH-1:0] stage_next [DEPTH][NUM_CH];
    logic [DEPTH-1:0]      vstage;
    logic [DEPTH-1:0]      vstage_next;

    logic [NUM_CH*DATA_WIDTH-1:0] data_tap;
    logic [NUM_CH-1:0]            valid_tap;

    // Next value of every data stage: shift on ce_in, otherwise hold.
    always_comb begin
        stage_next = stage;
        if (ce_in) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                stage_next[0][c] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_next[k] = stage[k-1];
            end
        end
    end

    // Next value of the shared valid chain: flush wins, then shift, then hold.
    always_comb begin
        vstage_next = vstage;
        if (flush_in) begin
            vstage_next = '0;
        end else if (ce_in) begin
            vstage_next[0] = valid_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                vstage_next[k] = vstage[k-1];
            end
        end
    end

    // Per-channel tap selection from the values being written this edge.
    // Out-of-range selects (0 or above DEPTH) clamp to the deepest stage.
    always_comb begin
        int unsigned eff;
        data_tap  = '0;
        valid_tap = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            eff = 32'(delay_sel_in[c*SEL_W +: SEL_W]);
            if (eff == 0 || eff > 32'(DEPTH)) begin
                eff = 32'(DEPTH);
            end
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (k == eff) begin
                    data_tap[c*DATA_WIDTH +: DATA_WIDTH] = stage_next[k-1][c];
                    valid_tap[c]                         = vstage_next[k-1];
                end
            end
        end
    end

    // State and output registers; reset clears everything and overrides ce/flush.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stage     <= '{default: '0};
            vstage    <= '0;
            data_out  <= '0;
            valid_out <= '0;
        end else begin
            stage     <= stage_next;
            vstage    <= vstage_next;
            data_out  <= data_tap;
            valid_out <= valid_tap;
        end
    end

endmodule

// File: tb/tb_multichan_delay_pipe.sv
// Self-checking bench for multichan_delay_pipe. The reference model keeps a
// history queue of accepted samples and reads each channel's output d samples back.
module tb_multichan_delay_pipe;

    localparam int NUM_CH = 3;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int SEL_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst, ce, flush, valid_in;
    logic [NUM_CH*DW-1:0]    data_in;
    logic [NUM_CH*SEL_W-1:0] sel;
    logic [NUM_CH*DW-1:0]    data_out;
    logic [NUM_CH-1:0]       valid_out;

    int errors = 0;
    int checks = 0;

    // Model: history of the last DEPTH accepted samples, newest at the back.
    logic [NUM_CH*DW-1:0] qd[$];
    logic                 qv[$];
    logic [NUM_CH*DW-1:0] exp_data;
    logic [NUM_CH-1:0]    exp_valid;

    multichan_delay_pipe #(
        .NUM_CH    (NUM_CH),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .ce_in       (ce),
        .flush_in    (flush),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .delay_sel_in(sel),
        .data_out    (data_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH*SEL_W-1:0] pack_sel(input int s0, input int s1, input int s2);
        logic [NUM_CH*SEL_W-1:0] v;
        v = '0;
        v[0*SEL_W +: SEL_W] = SEL_W'(s0);
        v[1*SEL_W +: SEL_W] = SEL_W'(s1);
        v[2*SEL_W +: SEL_W] = SEL_W'(s2);
        return v;
    endfunction

    function automatic int eff_delay(input int c);
        logic [NUM_CH*SEL_W-1:0] s;
        int d;
        s = sel;
        d = int'(s[c*SEL_W +: SEL_W]);
        if (d == 0 || d > DEPTH) d = DEPTH;
        return d;
    endfunction

    task automatic model_clear();
        qd.delete();
        qv.delete();
        for (int i = 0; i < DEPTH; i++) begin
            qd.push_back('0);
            qv.push_back(1'b0);
        end
    endtask

    // Drive one cycle, advance the model at the edge, settle 1 time unit after it.
    task automatic step(input logic r, input logic c, input logic f, input logic v,
                        input logic [NUM_CH*DW-1:0] d);
        logic [NUM_CH*DW-1:0] tmp;
        int dl;
        rst = r; ce = c; flush = f; valid_in = v; data_in = d;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (f) foreach (qv[i]) qv[i] = 1'b0;
            if (c) begin
                qd.push_back(d);
                qv.push_back(v && !f);
                void'(qd.pop_front());
                void'(qv.pop_front());
            end
        end
        exp_data  = '0;
        exp_valid = '0;
        if (!r) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                dl  = eff_delay(ch);
                tmp = qd[DEPTH - dl];
                exp_data[ch*DW +: DW] = tmp[ch*DW +: DW];
                exp_valid[ch]         = qv[DEPTH - dl];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        sel = pack_sel(1, 2, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        checks++;
        if (data_out !== '0 || valid_out !== '0) begin
            errors++;
            $display("FAIL reset_all: data_out=%h valid_out=%b required 0/0", data_out, valid_out);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
        step(1'b1, 1'b1, 1'b1, 1'b1, 24'h654321);
        checks++;
        if (data_out !== '0 || valid_out !== '0) begin
            errors++;
            $display("FAIL reset_flush_ce: data_out=%h valid_out=%b required 0/0", data_out, valid_out);
        end
    endtask

    task automatic test_latency();
        logic [NUM_CH-1:0] want_v;
        sel = pack_sel(1, 3, 4);
        step(1'b0, 1'b1, 1'b0, 1'b1, {8'hC0, 8'hB0, 8'hA0});
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
            want_v = {(n == 4), (n == 3), (n == 1)};
            checks++;
            if (valid_out !== want_v) begin
                errors++;
                $display("FAIL latency_valid n=%0d: valid_out=%b required %b", n, valid_out, want_v);
            end
            checks++;
            if ((n == 1 && data_out[7:0] !== 8'hA0) || (n == 3 && data_out[15:8] !== 8'hB0) ||
                (n == 4 && data_out[23:16] !== 8'hC0)) begin
                errors++;
                $display("FAIL latency_data n=%0d: data_out=%h required A0/B0/C0 in lane", n, data_out);
            end
            checks++;
            if (data_out !== exp_data || valid_out !== exp_valid) begin
                errors++;
                $display("FAIL latency_model n=%0d: data_out=%h valid_out=%b required %h %b",
                         n, data_out, valid_out, exp_data, exp_valid);
            end
        end
    endtask

    task automatic test_clamp();
        sel = pack_sel(0, 7, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, {8'h33, 8'h22, 8'h11});
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
            checks++;
            if (valid_out[1:0] !== {2{n == 4}} || valid_out[2] !== (n == 2)) begin
                errors++;
                $display("FAIL clamp n=%0d: valid_out=%b required ch0/ch1 at 4, ch2 at 2", n, valid_out);
            end
            if (n == 4) begin
                checks++;
                if (data_out[15:0] !== 16'h2211) begin
                    errors++;
                    $display("FAIL clamp_data: data_out=%h required low lanes 2211", data_out);
                end
            end
        end
    endtask

    task automatic test_stall();
        byte got[$];
        logic [NUM_CH*DW-1:0] frozen_d;
        logic [NUM_CH-1:0]    frozen_v;
        sel = pack_sel(2, 2, 2);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
        for (int b = 1; b <= 8; b++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, {3{8'(b)}});
            if (valid_out[0]) got.push_back(byte'(data_out[7:0]));
            checks++;
            if (data_out !== exp_data || valid_out !== exp_valid) begin
                errors++;
                $display("FAIL stall_model b=%0d: data_out=%h valid_out=%b required %h %b",
                         b, data_out, valid_out, exp_data, exp_valid);
            end
            if (b == 4) begin
                frozen_d = data_out;
                frozen_v = valid_out;
                for (int s = 0; s < 3; s++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b1, 24'hEEEEEE);
                    checks++;
                    if (data_out !== frozen_d || valid_out !== frozen_v) begin
                        errors++;
                        $display("FAIL stall_freeze s=%0d: data_out=%h valid_out=%b required %h %b",
                                 s, data_out, valid_out, frozen_d, frozen_v);
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
            if (valid_out[0]) got.push_back(byte'(data_out[7:0]));
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d valid samples, required 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== byte'(i + 1)) begin
                    errors++;
                    $display("FAIL stall_seq i=%0d: got %h required %h", i, got[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [NUM_CH*DW-1:0] prev;
        sel = pack_sel(4, 4, 4);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom));
        prev = data_out;
        step(1'b0, 1'b1, 1'b1, 1'b1, 24'h5A5A5A);
        for (int n = 0; n <= 4; n++) begin
            if (n > 0) begin
                prev = data_out;
                step(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom));
            end
            checks++;
            if (valid_out !== ((n == 4) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL flush_valid n=%0d: valid_out=%b required %b", n, valid_out,
                         (n == 4) ? 3'b111 : 3'b000);
            end
            checks++;
            if (data_out !== exp_data) begin
                errors++;
                $display("FAIL flush_data n=%0d: data_out=%h required %h (prev %h)",
                         n, data_out, exp_data, prev);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int first[NUM_CH];
        sel = pack_sel(1, 2, 3);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, {3{8'(i * 8'h11)}});
        step(1'b1, 1'b1, 1'b0, 1'b1, 24'hAAAAAA);
        checks++;
        if (data_out !== '0 || valid_out !== '0) begin
            errors++;
            $display("FAIL midreset: data_out=%h valid_out=%b required 0/0", data_out, valid_out);
        end
        for (int c = 0; c < NUM_CH; c++) first[c] = -1;
        for (int n = 1; n <= 5; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, {3{8'(n)}});
            for (int c = 0; c < NUM_CH; c++)
                if (valid_out[c] && first[c] < 0) first[c] = n;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (first[c] != c + 1) begin
                errors++;
                $display("FAIL midreset_latency ch%0d: first valid at %0d required %0d", c, first[c], c + 1);
            end
        end
    endtask

    task automatic test_random();
        logic r, c, f, v;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) sel = NUM_CH*SEL_W'($urandom);
            r = ($urandom_range(0, 49) == 0);
            c = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            v = $urandom_range(0, 1) == 1;
            step(r, c, f, v, 24'($urandom));
            checks++;
            if (data_out !== exp_data || valid_out !== exp_valid) begin
                errors++;
                $display("FAIL random i=%0d: data_out=%h valid_out=%b required %h %b",
                         i, data_out, valid_out, exp_data, exp_valid);
            end
            for (int a = 0; a < NUM_CH; a++)
                for (int b = a + 1; b < NUM_CH; b++)
                    if (eff_delay(a) == eff_delay(b)) begin
                        checks++;
                        if (valid_out[a] !== valid_out[b]) begin
                            errors++;
                            $display("FAIL equal_delay i=%0d ch%0d/ch%0d: valid_out=%b required equal bits",
                                     i, a, b, valid_out);
                        end
                    end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;
        sel = pack_sel(1, 1, 1);
        model_clear();
        test_reset();
        test_latency();
        test_clamp();
        test_stall();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
